// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags, overflow/underflow pulses
// and a selectable first-word-fall-through read mode.
module sync_fifo_flags #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AFULL_TH);
  localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              wr_ok;
  logic              rd_ok;

  assign count = cnt;

  // Acceptance from pre-edge flags and next occupancy
  always_comb begin
    wr_ok   = wr & ~full;
    rd_ok   = rd & ~empty;
    cnt_nxt = cnt;
    if (wr_ok && !rd_ok)
      cnt_nxt = cnt + 1'b1;
    else if (rd_ok && !wr_ok)
      cnt_nxt = cnt - 1'b1;
  end

  // Pointers, count, flags and error pulses; flags track post-edge occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok)
        rd_ptr <= rd_ptr + 1'b1;
      cnt          <= cnt_nxt;
      empty        <= (cnt_nxt == '0);
      full         <= (cnt_nxt == DEPTH_C);
      almost_full  <= (cnt_nxt >= AF_C);
      almost_empty <= (cnt_nxt <= AE_C);
      overflow     <= wr & full;
      underflow    <= rd & empty;
    end
  end

  // Storage write; contents survive reset, but reset blocks the write
  always_ff @(posedge clk) begin
    if (wr_ok && !rst)
      mem[wr_ptr] <= din;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown directly; forced to zero while empty so reset reads 0
      always_comb begin
        dout = '0;
        if (!empty)
          dout = mem[rd_ptr];
      end
    end else begin : g_std
      // Registered read data, updated only on an accepted read
      always_ff @(posedge clk) begin
        if (rst)
          dout <= '0;
        else if (rd_ok)
          dout <= mem[rd_ptr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Testbench for sync_fifo_flags: a standard-read and an FWFT instance share
// stimulus and are checked every cycle against a queue-based model.
module tb_sync_fifo_flags;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AFT    = 14;
  localparam int AET    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr  = 1'b0;
  logic              rd  = 1'b0;
  logic [DATA_W-1:0] din = '0;

  logic [DATA_W-1:0] dout0, dout1;
  logic              full0, empty0, af0, ae0, ovf0, udf0;
  logic              full1, empty1, af1, ae1, ovf1, udf1;
  logic [4:0]        cnt0, cnt1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFT),
                    .AEMPTY_TH(AET), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .din(din), .dout(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ovf0), .underflow(udf0));

  sync_fifo_flags #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFT),
                    .AEMPTY_TH(AET), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .din(din), .dout(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ovf1), .underflow(udf1));

  // Reference model state
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_dout = '0;
  logic              m_ovf  = 1'b0;
  logic              m_udf  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model update on each active edge from the rules of acceptance
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      automatic bit f = (q.size() == DEPTH);
      automatic bit e = (q.size() == 0);
      m_ovf = wr && f;
      m_udf = rd && e;
      if (rd && !e) m_dout = q.pop_front();
      if (wr && !f) q.push_back(din);
    end
  end

  // Compare both instances against the model away from the active edge
  always @(negedge clk) begin
    automatic int n = q.size();
    check("count_std",  32'(cnt0),  32'(n));
    check("count_fwft", 32'(cnt1),  32'(n));
    check("empty_std",  32'(empty0), 32'(n == 0));
    check("empty_fwft", 32'(empty1), 32'(n == 0));
    check("full_std",   32'(full0),  32'(n == DEPTH));
    check("full_fwft",  32'(full1),  32'(n == DEPTH));
    check("afull_std",  32'(af0),    32'(n >= AFT));
    check("afull_fwft", 32'(af1),    32'(n >= AFT));
    check("aempty_std", 32'(ae0),    32'(n <= AET));
    check("aempty_fwft",32'(ae1),    32'(n <= AET));
    check("ovf_std",    32'(ovf0),   32'(m_ovf));
    check("ovf_fwft",   32'(ovf1),   32'(m_ovf));
    check("udf_std",    32'(udf0),   32'(m_udf));
    check("udf_fwft",   32'(udf1),   32'(m_udf));
    check("dout_std",   32'(dout0),  32'(m_dout));
    if (n > 0) check("dout_fwft", 32'(dout1), 32'(q[0]));
  end

  // Apply one cycle of inputs; returns just after that edge's updates
  task automatic step(input bit w, input bit r, input logic [DATA_W-1:0] d, input bit rs);
    wr = w; rd = r; din = d; rst = rs;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset held two cycles with wr=rd=1
    step(1, 1, 8'h55, 1);
    step(1, 1, 8'h66, 1);
    check("rst_count", 32'(cnt0), 0);
    check("rst_empty", 32'(empty0), 1);
    check("rst_full",  32'(full0), 0);
    check("rst_ae",    32'(ae0), 1);
    check("rst_af",    32'(af0), 0);
    check("rst_dout",  32'(dout0), 0);
    check("rst_ovf",   32'(ovf0 | udf0), 0);

    // Fill 1..16
    for (int k = 1; k <= 16; k++) begin
      step(1, 0, 8'(k), 0);
      check("fill_count", 32'(cnt0), 32'(k));
      check("fill_ae",    32'(ae0), 32'(k <= 2));
      check("fill_af",    32'(af0), 32'(k >= 14));
    end
    check("fill_full", 32'(full0), 1);

    // Rejected write of 99
    step(1, 0, 8'd99, 0);
    check("ovf_pulse", 32'(ovf0), 1);
    check("ovf_count", 32'(cnt0), 16);
    step(0, 0, 8'd0, 0);
    check("ovf_clear", 32'(ovf0), 0);

    // Drain 1..16, then an extra read
    for (int k = 1; k <= 16; k++) begin
      step(0, 1, 8'd0, 0);
      check("drain_dout", 32'(dout0), 32'(k));
    end
    step(0, 1, 8'd0, 0);
    check("udf_pulse", 32'(udf0), 1);
    check("udf_dout",  32'(dout0), 16);
    check("udf_empty", 32'(empty0), 1);

    // Preload 5 then sustained concurrent traffic across pointer wraps
    for (int k = 0; k < 5; k++) step(1, 0, 8'(8'h20 + k), 0);
    for (int k = 0; k < 40; k++) begin
      step(1, 1, 8'(8'h25 + k), 0);
      check("wrap_dout", 32'(dout0), 32'(8'h20 + k));
    end
    check("wrap_count", 32'(cnt0), 5);

    // Full with wr=rd
    while (!full0) step(1, 0, 8'($urandom), 0);
    step(1, 1, 8'hEE, 0);
    check("full_rw_count", 32'(cnt0), 15);
    check("full_rw_ovf",   32'(ovf0), 1);

    // Empty with wr=rd
    while (!empty0) step(0, 1, 8'd0, 0);
    step(1, 1, 8'h3C, 0);
    check("empty_rw_count", 32'(cnt0), 1);
    check("empty_rw_udf",   32'(udf0), 1);
    check("empty_rw_fwft",  32'(dout1), 32'h3C);

    // Reset with 7 words stored
    for (int k = 0; k < 6; k++) step(1, 0, 8'(8'h70 + k), 0);
    step(0, 0, 8'd0, 1);
    check("midrst_count", 32'(cnt0), 0);
    check("midrst_empty", 32'(empty0), 1);
    step(0, 1, 8'd0, 0);
    check("midrst_udf",  32'(udf0), 1);
    check("midrst_dout", 32'(dout0), 0);

    // FWFT head visible without a read
    step(0, 0, 8'd0, 0);
    step(1, 0, 8'hA5, 0);
    check("fwft_empty", 32'(empty1), 0);
    check("fwft_dout",  32'(dout1), 32'hA5);
    step(0, 1, 8'd0, 0);
    check("fwft_pop_empty", 32'(empty1), 1);

    // Randomised traffic with occasional reset
    for (int k = 0; k < 3000; k++) begin
      automatic int mode = (k / 500) % 3;
      automatic bit w = ($urandom_range(99) < (mode == 0 ? 70 : mode == 1 ? 30 : 50));
      automatic bit r = ($urandom_range(99) < (mode == 0 ? 30 : mode == 1 ? 70 : 50));
      step(w, r, 8'($urandom), ($urandom_range(299) == 0));
    end

    step(0, 0, 8'd0, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
